// File: rtl/seg_pkg.sv
//------------------------------------------------------------------------------
// Module  : seg_pkg
// Purpose : Glyph table, blank constant and nibble-to-segment decode helper.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Entry n is the a..g pattern for nibble n (entry 15 is leftmost).
    localparam logic [15:0][6:0] SEG_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] seg_decode(input logic [3:0] nib, input logic dp);
        return {dp, SEG_GLYPH[nib]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_scan_array_if.sv
//------------------------------------------------------------------------------
// Module  : seg_scan_array_if
// Purpose : Display-data and pin bundle between application and scan driver.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface seg_scan_array_if #(
    parameter int BANKS           = 2,
    parameter int DIGITS_PER_BANK = 4
);
    localparam int N = BANKS * DIGITS_PER_BANK;

    logic                 load_in;
    logic [4*N-1:0]       bcd_in;
    logic [N-1:0]         dot_in;
    logic [N-1:0]         blink_in;
    logic                 lz_en_in;
    logic [N-1:0]         cs_out;
    logic [8*BANKS-1:0]   seg_out;
    logic                 frame_out;

    modport master (
        output load_in, bcd_in, dot_in, blink_in, lz_en_in,
        input  cs_out, seg_out, frame_out
    );

    modport slave (
        input  load_in, bcd_in, dot_in, blink_in, lz_en_in,
        output cs_out, seg_out, frame_out
    );

endinterface

`default_nettype wire

// File: rtl/seg_scan_timer.sv
//------------------------------------------------------------------------------
// Module  : seg_scan_timer
// Purpose : Dwell counter and digit index with guard flag and frame strobe.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_timer #(
    parameter int DWELL           = 10,
    parameter int GUARD_CYCLES    = 2,
    parameter int DIGITS_PER_BANK = 4,
    parameter int IW              = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    output logic [IW-1:0]      digit,
    output logic               guard,
    output logic               boundary
);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] c_last_count = CW'(DWELL - 1);
    localparam logic [CW-1:0] c_guard      = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] c_last_digit = IW'(DIGITS_PER_BANK - 1);

    logic [CW-1:0] r_count;
    logic [IW-1:0] r_digit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_digit <= '0;
        end else if (r_count == c_last_count) begin
            r_count <= '0;
            r_digit <= (r_digit == c_last_digit) ? '0 : r_digit + IW'(1);
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign digit    = r_digit;
    assign guard    = (r_count < c_guard);
    assign boundary = (r_count == c_last_count) && (r_digit == c_last_digit);

endmodule

`default_nettype wire

// File: rtl/seg_scan_array.sv
//------------------------------------------------------------------------------
// Module  : seg_scan_array
// Purpose : Multi-bank multiplexed 7-segment driver with double buffering,
//           leading-zero suppression and guard gap. SEG_BLINK_EN adds blink.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module seg_scan_array
    import seg_pkg::*;
#(
    parameter int FREQUENCY_IN    = 50_000_000,
    parameter int BANKS           = 2,
    parameter int DIGITS_PER_BANK = 4,
    parameter int DIGIT_HZ        = 1000,
    parameter int GUARD_CYCLES    = 2,
    parameter int BLINK_HZ        = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    seg_scan_array_if.slave  bus
);
    localparam int N     = BANKS * DIGITS_PER_BANK;
    localparam int DWELL = FREQUENCY_IN / DIGIT_HZ;
    localparam int IW    = (DIGITS_PER_BANK > 1) ? $clog2(DIGITS_PER_BANK) : 1;
    localparam logic [DIGITS_PER_BANK-1:0] c_sel_lsb = DIGITS_PER_BANK'(1);

    logic [IW-1:0]      w_digit;
    logic               w_guard;
    logic               w_boundary;
    logic               w_commit;
    logic [4*N-1:0]     r_cap_bcd, r_sh_bcd;
    logic [N-1:0]       r_cap_dot, r_sh_dot;
    logic               r_pending;
    logic [N-1:0]       w_run, w_blank, w_off;
    logic [N-1:0]       w_cs;
    logic [8*BANKS-1:0] w_seg;

    seg_scan_timer #(
        .DWELL           (DWELL),
        .GUARD_CYCLES    (GUARD_CYCLES),
        .DIGITS_PER_BANK (DIGITS_PER_BANK),
        .IW              (IW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .digit    (w_digit),
        .guard    (w_guard),
        .boundary (w_boundary)
    );

    assign w_commit = w_boundary && r_pending;

    // A load on the boundary cycle wins the pending flag after the old capture commits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_bcd <= '0;
            r_cap_dot <= '0;
            r_sh_bcd  <= '0;
            r_sh_dot  <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_commit) begin
                r_sh_bcd  <= r_cap_bcd;
                r_sh_dot  <= r_cap_dot;
                r_pending <= 1'b0;
            end
            if (bus.load_in) begin
                r_cap_bcd <= bus.bcd_in;
                r_cap_dot <= bus.dot_in;
                r_pending <= 1'b1;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int HALF = FREQUENCY_IN / (2 * BLINK_HZ);
    localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [HW-1:0] c_half_last = HW'(HALF - 1);

    logic [N-1:0]  r_cap_blink, r_sh_blink;
    logic [HW-1:0] r_blink_cnt;
    logic          r_blink_on;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_blink <= '0;
            r_sh_blink  <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            if (w_commit)    r_sh_blink  <= r_cap_blink;
            if (bus.load_in) r_cap_blink <= bus.blink_in;
            if (r_blink_cnt == c_half_last) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + HW'(1);
            end
        end
    end

    assign w_off = r_sh_blink & {N{~r_blink_on}};
`else
    wire w_unused_blink = ^bus.blink_in;
    assign w_off = '0;
`endif

    // w_run[g]: digit g and every digit above it are zero with dp clear.
    for (genvar g = 0; g < N; g++) begin : g_lz
        logic w_zero;
        assign w_zero = (r_sh_bcd[4*g +: 4] == 4'h0) && !r_sh_dot[g];
        if (g == N - 1) begin : g_top
            assign w_run[g] = w_zero;
        end else begin : g_rest
            assign w_run[g] = w_zero && w_run[g+1];
        end
        assign w_blank[g] = (g != 0) && bus.lz_en_in && w_run[g];
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [4*DIGITS_PER_BANK-1:0] w_bank_bcd;
        logic [DIGITS_PER_BANK-1:0]   w_bank_dot, w_bank_hide;
        logic [3:0]                   w_nib;
        assign w_bank_bcd  = r_sh_bcd[4*DIGITS_PER_BANK*b +: 4*DIGITS_PER_BANK];
        assign w_bank_dot  = r_sh_dot[DIGITS_PER_BANK*b +: DIGITS_PER_BANK];
        assign w_bank_hide = w_blank[DIGITS_PER_BANK*b +: DIGITS_PER_BANK]
                           | w_off[DIGITS_PER_BANK*b +: DIGITS_PER_BANK];
        assign w_nib       = w_bank_bcd[{w_digit, 2'b00} +: 4];
        assign w_seg[8*b +: 8] = w_bank_hide[w_digit] ? SEG_BLANK
                                                      : seg_decode(w_nib, w_bank_dot[w_digit]);
    end

    always_comb begin
        w_cs = '0;
        if (!w_guard) begin
            w_cs = {BANKS{c_sel_lsb << w_digit}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.cs_out    <= '0;
            bus.seg_out   <= '0;
            bus.frame_out <= 1'b0;
        end else begin
            bus.cs_out    <= w_cs;
            bus.seg_out   <= w_seg;
            bus.frame_out <= w_boundary;
        end
    end

endmodule

`default_nettype wire
